rf_write_arbiter: RTL and testbench



---
 rtl/rf_arb_pkg.sv | 15 +
 rtl/rf_write_arbiter_sync2.sv | 25 ++
 rtl/rf_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter,
// the register file and the write-back stage.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rf_write_arbiter_sync2.sv
// Two-flop synchroniser for asynchronous level signals entering the RF clock
// domain; a change on d is visible on q after the second rising edge.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep the two stages distinct flops; blocking would collapse them into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ
// 4-phase requesters. Define RF_WRITE_ARBITER_TIMEOUT_EN for the rf_ack watchdog.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          ack,
    input  logic [NUM_REQ*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wr_data,
    output logic                        rf_req,
    input  logic                        rf_ack,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_addr_w,
    output logic [DATA_W-1:0]           rf_data_in,
    output logic                        busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                        timeout_err
);

    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req_s;
    logic               rf_ack_s;
    logic [NUM_REQ-1:0] pending;
    logic [GID_W-1:0]   ptr;
    logic [GID_W-1:0]   pick;
    logic               abort;
    arb_state_t         state;

    sync2 #(.WIDTH(NUM_REQ)) u_req_sync (.clk(clk), .rst_n(rst_n), .d(req),    .q(req_s));
    sync2 #(.WIDTH(1))       u_ack_sync (.clk(clk), .rst_n(rst_n), .d(rf_ack), .q(rf_ack_s));

    // First pending requester searching from start upward, wrapping modulo NUM_REQ.
    function automatic logic [GID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                                 input logic [GID_W-1:0]   start);
        logic [GID_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!found && pend[idx]) begin
                sel   = GID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // A requester whose ack is still high has not finished its return-to-zero.
    assign pending = req_s & ~ack;
    assign pick    = rr_pick(pending, ptr);
    assign rf_we   = rf_req;
    assign busy    = (state != IDLE);

`ifdef RF_WRITE_ARBITER_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;

    // Still waiting on an rf_ack edge in DRIVE or RELEASE.
    assign waiting = ((state == DRIVE) && !rf_ack_s) || ((state == RELEASE) && rf_ack_s);
    assign abort   = waiting && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt <= waiting ? tmo_cnt + 1'b1 : '0;
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign abort              = 1'b0;
    assign timeout_err        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_id   <= '0;
            ack        <= '0;
            rf_req     <= 1'b0;
            rf_addr_w  <= '0;
            rf_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant_id   <= pick;
                        rf_addr_w  <= wr_addr[int'(pick)*ADDR_W +: ADDR_W];
                        rf_data_in <= wr_data[int'(pick)*DATA_W +: DATA_W];
                        rf_req     <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (rf_ack_s) begin
                        rf_req <= 1'b0;
                        state  <= RELEASE;
                    end else if (abort) begin
                        rf_req        <= 1'b0;
                        ack[grant_id] <= 1'b1;
                        state         <= DONE;
                    end
                end
                RELEASE: begin
                    if (!rf_ack_s || abort) begin
                        ack[grant_id] <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (!req_s[grant_id]) begin
                        ack[grant_id] <= 1'b0;
                        ptr           <= GID_W'((int'(grant_id) + 1) % NUM_REQ);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a hand-driven register-file ack.
// Define RF_WRITE_ARBITER_TIMEOUT_EN to also exercise the rf_ack watchdog.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rf_req;
    logic        rf_ack;
    logic        rf_we;
    logic [3:0]  rf_addr_w;
    logic [15:0] rf_data_in;
    logic        busy;
    logic [0:0]  grant_id;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int n;

    rf_write_arbiter #(
        .NUM_REQ(2), .ADDR_W(4), .DATA_W(16), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rf_req(rf_req), .rf_ack(rf_ack), .rf_we(rf_we),
        .rf_addr_w(rf_addr_w), .rf_data_in(rf_data_in),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic wait_rf_req(input logic v, input string tag);
        for (int i = 0; i < 40 && rf_req !== v; i++) tick(1);
        check(tag, rf_req, v);
    endtask

    task automatic wait_ack(input logic [1:0] v, input string tag);
        for (int i = 0; i < 40 && ack !== v; i++) tick(1);
        check(tag, ack, v);
    endtask

    // Register-file side: ack the pending write and return to zero.
    task automatic rf_complete(input string tag);
        rf_ack = 1'b1;
        wait_rf_req(1'b0, tag);
        rf_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, {ack, rf_req, rf_we, busy, grant_id, timeout_err}, 0);
        check({tag, "_addr"}, rf_addr_w, 0);
        check({tag, "_data"}, rf_data_in, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 2'b00;
        rf_ack  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // Single write from requester 0, latency, stability and ack ordering.
        wr_addr[3:0]  = 4'h3;
        wr_data[15:0] = 16'hBEEF;
        req[0]        = 1'b1;
        tick(2);
        check("lat_early", rf_req, 1'b0);
        tick(1);
        check("lat_rf_req", {rf_req, rf_we, busy}, 3'b111);
        check("single_addr", rf_addr_w, 4'h3);
        check("single_data", rf_data_in, 16'hBEEF);
        check("single_gid", grant_id, 0);
        wr_data[15:0] = 16'h1234;
        tick(2);
        check("stable_data", rf_data_in, 16'hBEEF);
        rf_ack = 1'b1;
        wait_rf_req(1'b0, "single_rf_drop");
        check("ack_not_yet", ack, 2'b00);
        rf_ack = 1'b0;
        tick(2);
        check("ack_wait_rz", ack, 2'b00);
        tick(1);
        check("ack_rise", ack, 2'b01);
        req[0] = 1'b0;
        tick(2);
        check("ack_hold", ack, 2'b01);
        tick(1);
        check("ack_fall", {ack, busy}, 3'b000);
        check("hold_addr", rf_addr_w, 4'h3);

        // Tie with ptr rotated to 1 by the previous grant.
        wr_addr = {4'hA, 4'h5};
        wr_data = {16'hAAAA, 16'h5555};
        req     = 2'b11;
        wait_rf_req(1'b1, "rot_rf_req1");
        check("rot_first_gid", grant_id, 1);
        check("rot_first_addr", rf_addr_w, 4'hA);
        check("rot_first_data", rf_data_in, 16'hAAAA);
        rf_complete("rot_rf_drop1");
        wait_ack(2'b10, "rot_ack1");
        req[1] = 1'b0;
        wait_rf_req(1'b1, "rot_rf_req0");
        check("rot_second_gid", grant_id, 0);
        check("rot_second_data", rf_data_in, 16'h5555);
        rf_complete("rot_rf_drop0");
        wait_ack(2'b01, "rot_ack0");
        req[0] = 1'b0;
        wait_ack(2'b00, "rot_ack0_fall");
        check("rot_idle", busy, 1'b0);

        // Reset asserted mid-DRIVE.
        req[0] = 1'b1;
        wait_rf_req(1'b1, "mid_rf_req");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check("mid_idle", {busy, rf_req, ack}, 0);

        // Tie after reset: requester 0 first, then 1.
        wr_addr = {4'hC, 4'h9};
        wr_data = {16'hC0DE, 16'h9999};
        req     = 2'b11;
        wait_rf_req(1'b1, "tie_rf_req0");
        check("tie_first_gid", grant_id, 0);
        check("tie_first_addr", rf_addr_w, 4'h9);
        rf_complete("tie_rf_drop0");
        wait_ack(2'b01, "tie_ack0");
        req[0] = 1'b0;
        wait_rf_req(1'b1, "tie_rf_req1");
        check("tie_second_gid", grant_id, 1);
        check("tie_second_data", rf_data_in, 16'hC0DE);
        rf_complete("tie_rf_drop1");
        wait_ack(2'b10, "tie_ack1");
        req[1] = 1'b0;
        wait_ack(2'b00, "tie_ack1_fall");

        // Requester 1 drops req before being acked.
        wr_addr[7:4]   = 4'hE;
        wr_data[31:16] = 16'hCAFE;
        req[1]         = 1'b1;
        tick(4);
        req[1] = 1'b0;
        check("viol_rf_req", {rf_req, grant_id}, 2'b11);
        check("viol_addr", rf_addr_w, 4'hE);
        check("viol_data", rf_data_in, 16'hCAFE);
        rf_complete("viol_rf_drop");
        wait_ack(2'b10, "viol_ack");
        n = 0;
        while (ack[1] === 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        check("viol_ack_width", n, 1);
        check("viol_idle", {busy, ack}, 0);

`ifdef RF_WRITE_ARBITER_TIMEOUT_EN
        // rf_ack never arrives: watchdog aborts after TIMEOUT_CYC cycles.
        wr_addr[3:0]  = 4'h7;
        wr_data[15:0] = 16'h55AA;
        req[0]        = 1'b1;
        wait_rf_req(1'b1, "tmo_rf_req");
        n = 0;
        while (rf_req === 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        check("tmo_cycles", n, 10);
        check("tmo_err", timeout_err, 1'b1);
        check("tmo_ack", ack, 2'b01);
        req[0] = 1'b0;
        wait_ack(2'b00, "tmo_ack_fall");
        tick(3);
        check("tmo_sticky", {timeout_err, busy}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("tmo_reset", timeout_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
